// File: rtl/ahb_single_master_pkg.sv
// Shared AHB 2.0 encodings and the single-master FSM/command types.
package ahb_single_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Non-cacheable, non-bufferable, privileged data access.
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_RESP2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ahb_single_master.sv
// AHB 2.0 master issuing one SINGLE transfer per command; handles OKAY/ERROR/RETRY/SPLIT,
// re-arbitrates after RETRY/SPLIT and reports one registered rsp_valid pulse per command.
module ahb_single_master
  import ahb_single_master_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 8
) (
  input  logic        HCLK,
  input  logic        HRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  input  logic        HGRANT,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA,
  output logic        HBUSREQ,
  output logic        HLOCK,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA
);

  localparam logic [7:0] MAX_RETRY_L = MAX_RETRY[7:0];

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  retry_inc;
  logic        own_q;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    retry_d      = retry_q;
    retry_inc    = sat_inc8(retry_q);
    rsp_valid_d  = 1'b0;
    rsp_err_d    = rsp_err_q;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = '{write: cmd_write, addr: cmd_addr, size: cmd_size, wdata: cmd_wdata};
          retry_d = 8'd0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (HREADY && HGRANT) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        // A grant lost during this cycle only affects the next address phase.
        if (HREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
          if (HRESP == HRESP_OKAY) begin
            rsp_err_d    = 1'b0;
            rsp_status_d = HRESP_OKAY;
            rsp_rdata_d  = cmd_q.write ? 32'd0 : HRDATA;
          end else begin
            // Non-OKAY without the two-cycle form is a slave protocol violation.
            rsp_err_d    = 1'b1;
            rsp_status_d = HRESP_ERROR;
            rsp_rdata_d  = 32'd0;
          end
        end else if (HRESP != HRESP_OKAY) begin
          state_d = ST_RESP2;
        end
      end
      ST_RESP2: begin
        if (HREADY) begin
          case (HRESP)
            HRESP_RETRY: begin
              retry_d = retry_inc;
              if (retry_inc > MAX_RETRY_L) begin
                rsp_valid_d  = 1'b1;
                rsp_err_d    = 1'b1;
                rsp_status_d = HRESP_RETRY;
                rsp_rdata_d  = 32'd0;
                state_d      = ST_IDLE;
              end else begin
                state_d = ST_REQ;
              end
            end
            HRESP_SPLIT: state_d = ST_REQ;
            default: begin
              rsp_valid_d  = 1'b1;
              rsp_err_d    = 1'b1;
              rsp_status_d = HRESP_ERROR;
              rsp_rdata_d  = 32'd0;
              state_d      = ST_IDLE;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      retry_q      <= 8'd0;
      own_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_status_q <= 2'b00;
      rsp_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      retry_q      <= retry_d;
      if (HREADY) own_q <= HGRANT;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE) && !HRST;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_status = rsp_status_q;
  assign rsp_rdata  = rsp_rdata_q;

  assign HBUSREQ = (state_q == ST_REQ) || (state_q == ST_ADDR);
  assign HLOCK   = 1'b0;
  assign HTRANS  = (state_q == ST_ADDR && own_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR   = cmd_q.addr;
  assign HWRITE  = cmd_q.write;
  assign HSIZE   = cmd_q.size;
  assign HBURST  = HBURST_SINGLE;
  assign HPROT   = HPROT_DEFAULT;
  assign HWDATA  = cmd_q.wdata;

endmodule
